// File: rtl/rgb_pwm_driver_if.sv
// ---------------------------------------------------------------------------
// rgb_pwm_driver_if
//   Duty-update bus for rgb_pwm_driver.
//
//   Handshake: in_valid is a 1-clk strobe that qualifies duty_r/g/b. There is
//   no ready signal. The slave accepts every strobe in the cycle it is
//   presented. The slave raises pending while an accepted update waits to be
//   applied at the next PWM period boundary.
//
//   Signals
//     in_valid  master->slave  duty_r/g/b valid this cycle
//     duty_r    master->slave  red duty   (DUTY_W bits)
//     duty_g    master->slave  green duty (DUTY_W bits)
//     duty_b    master->slave  blue duty  (DUTY_W bits)
//     pending   slave->master  update buffered, not yet applied
// ---------------------------------------------------------------------------
interface rgb_pwm_driver_if #(
  parameter int DUTY_W = 8
);
  logic              in_valid;
  logic [DUTY_W-1:0] duty_r;
  logic [DUTY_W-1:0] duty_g;
  logic [DUTY_W-1:0] duty_b;
  logic              pending;

  modport master (
    output in_valid, duty_r, duty_g, duty_b,
    input  pending
  );

  modport slave (
    input  in_valid, duty_r, duty_g, duty_b,
    output pending
  );
endinterface

// File: rtl/rgb_pwm_driver.sv
// ---------------------------------------------------------------------------
// rgb_pwm_driver
//   Three-channel PWM generator for the SB_RGBA_DRV RGBxPWM pins. Duty values
//   arrive on the bus interface. They are double-buffered and take effect only
//   at a PWM period boundary, so a colour change never glitches mid-period.
//
//   Parameters
//     PRESCALE  clk cycles per PWM step (>=1)
//     DUTY_W    duty / PWM counter width; period = 2**DUTY_W steps
//
//   Ports
//     clk           system clock
//     rst           synchronous reset, active-high (overrides en and in_valid)
//     en            run enable; low freezes counters and forces outputs low
//     bus           rgb_pwm_driver_if.slave: in_valid, duty_r/g/b in; pending out
//     pwm_r/g/b     registered PWM outputs
//     period_start  1-clk pulse, one cycle after each period boundary
//
//   Optional feature (macro RGB_PWM_PHASE_STAGGER_EN)
//     When defined, the green and blue comparators see the PWM count offset by
//     one third and two thirds of a period. This spreads LED turn-on edges
//     while leaving duty per period unchanged.
// ---------------------------------------------------------------------------
module rgb_pwm_driver #(
  parameter int PRESCALE = 8,
  parameter int DUTY_W   = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           en,
  rgb_pwm_driver_if.slave bus,
  output logic           pwm_r,
  output logic           pwm_g,
  output logic           pwm_b,
  output logic           period_start
);

  localparam int                PRE_W    = $clog2(PRESCALE) + 1;
  localparam logic [PRE_W-1:0]  PRE_LAST = PRE_W'(PRESCALE - 1);
  localparam logic [DUTY_W-1:0] CNT_LAST = '1;

  logic [PRE_W-1:0]  pre_cnt;
  logic [DUTY_W-1:0] pwm_cnt;
  logic [DUTY_W-1:0] active_r, active_g, active_b;
  logic [DUTY_W-1:0] pend_r, pend_g, pend_b;
  logic              pending_q;
  logic              tick;
  logic              boundary;
  logic [DUTY_W-1:0] cmp_r, cmp_g, cmp_b;

  // With PRESCALE=1, PRE_LAST is 0 and pre_cnt never leaves 0, so tick = en.
  assign tick     = en & (pre_cnt == PRE_LAST);
  assign boundary = tick & (pwm_cnt == CNT_LAST);

`ifdef RGB_PWM_PHASE_STAGGER_EN
  localparam logic [DUTY_W-1:0] OFS_G = DUTY_W'((2 ** DUTY_W) / 3);
  localparam logic [DUTY_W-1:0] OFS_B = DUTY_W'(2 * ((2 ** DUTY_W) / 3));

  // The additions wrap modulo 2**DUTY_W by truncation.
  assign cmp_r = pwm_cnt;
  assign cmp_g = pwm_cnt + OFS_G;
  assign cmp_b = pwm_cnt + OFS_B;
`else
  assign cmp_r = pwm_cnt;
  assign cmp_g = pwm_cnt;
  assign cmp_b = pwm_cnt;
`endif

  // Prescaler and PWM step counter. Both hold while en is low.
  always_ff @(posedge clk) begin
    if (rst) begin
      pre_cnt <= '0;
      pwm_cnt <= '0;
    end else begin
      if (en) begin
        pre_cnt <= tick ? '0 : pre_cnt + PRE_W'(1);
      end
      if (tick) begin
        pwm_cnt <= pwm_cnt + DUTY_W'(1);
      end
    end
  end

  // Double buffer. The apply reads pend_* before this cycle's write lands.
  // A strobe in the boundary cycle therefore stays pending for the next
  // period. The strobe also wins over the boundary clear of pending_q.
  always_ff @(posedge clk) begin
    if (rst) begin
      pend_r    <= '0;
      pend_g    <= '0;
      pend_b    <= '0;
      active_r  <= '0;
      active_g  <= '0;
      active_b  <= '0;
      pending_q <= 1'b0;
    end else begin
      if (boundary && pending_q) begin
        active_r <= pend_r;
        active_g <= pend_g;
        active_b <= pend_b;
      end
      if (bus.in_valid) begin
        pend_r    <= bus.duty_r;
        pend_g    <= bus.duty_g;
        pend_b    <= bus.duty_b;
        pending_q <= 1'b1;
      end else if (boundary) begin
        pending_q <= 1'b0;
      end
    end
  end

  // Output registers, one clk behind pwm_cnt. Duty D gives D high steps.
  always_ff @(posedge clk) begin
    if (rst) begin
      pwm_r        <= 1'b0;
      pwm_g        <= 1'b0;
      pwm_b        <= 1'b0;
      period_start <= 1'b0;
    end else begin
      pwm_r        <= en & (cmp_r < active_r);
      pwm_g        <= en & (cmp_g < active_g);
      pwm_b        <= en & (cmp_b < active_b);
      period_start <= boundary;
    end
  end

  assign bus.pending = pending_q;

endmodule

// File: tb/tb_rgb_pwm_driver.sv
// ---------------------------------------------------------------------------
// tb_rgb_pwm_driver
//   Directed bench for rgb_pwm_driver with PRESCALE=1, DUTY_W=8.
//
//   The model below tracks the number of enabled clocks since reset and
//   derives the PWM step, tick and boundary from it arithmetically. A
//   per-cycle compare checks all outputs against the model. The directed
//   scenarios add literal expectations, such as high counts per period and
//   edge positions.
// ---------------------------------------------------------------------------
module tb_rgb_pwm_driver;
  localparam int DUTY_W   = 8;
  localparam int PRESCALE = 1;
  localparam int PERIOD   = 2 ** DUTY_W;

  logic clk = 1'b0;
  logic rst;
  logic en;
  logic pwm_r, pwm_g, pwm_b, period_start;

  rgb_pwm_driver_if #(.DUTY_W(DUTY_W)) bus ();

  rgb_pwm_driver #(.PRESCALE(PRESCALE), .DUTY_W(DUTY_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .en           (en),
    .bus          (bus),
    .pwm_r        (pwm_r),
    .pwm_g        (pwm_g),
    .pwm_b        (pwm_b),
    .period_start (period_start)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- counters / checker ----------------
  int n_cmp = 0;
  int n_mis = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
`ifdef RGB_PWM_PHASE_STAGGER_EN
  int ofs [3] = '{0, PERIOD / 3, 2 * (PERIOD / 3)};
`else
  int ofs [3] = '{0, 0, 0};
`endif
  int       m_en_cycles;
  int       m_act  [3];
  int       m_pend [3];
  bit       m_pending;
  bit       m_valid = 1'b0;
  logic [4:0] m_exp;       // {pwm_r, pwm_g, pwm_b, period_start, pending}

  always @(posedge clk) begin
    int   step;
    bit   tick;
    bit   bnd;
    logic [2:0] p;
    if (rst) begin
      m_en_cycles = 0;
      m_act       = '{0, 0, 0};
      m_pend      = '{0, 0, 0};
      m_pending   = 1'b0;
      m_exp       = '0;
      m_valid     = 1'b1;
    end else begin
      step = (m_en_cycles / PRESCALE) % PERIOD;
      tick = en && ((m_en_cycles % PRESCALE) == PRESCALE - 1);
      bnd  = tick && (step == PERIOD - 1);
      for (int c = 0; c < 3; c++) begin
        p[2-c] = en && (((step + ofs[c]) % PERIOD) < m_act[c]);
      end
      if (bnd && m_pending) begin
        m_act     = m_pend;
        m_pending = 1'b0;
      end
      if (bus.in_valid === 1'b1) begin
        m_pend    = '{int'(bus.duty_r), int'(bus.duty_g), int'(bus.duty_b)};
        m_pending = 1'b1;
      end
      if (en) m_en_cycles++;
      m_exp = {p, bnd, m_pending};
    end
  end

  // Per-cycle compare, away from the active edge.
  always @(negedge clk) begin
    if (m_valid) begin
      check("cycle_outputs", 32'({pwm_r, pwm_g, pwm_b, period_start, bus.pending}), 32'(m_exp));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic strobe(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
    bus.duty_r   = r;
    bus.duty_g   = g;
    bus.duty_b   = b;
    bus.in_valid = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  // Returns at the negedge where period_start is seen (pwm_cnt==0 cycle).
  task automatic wait_ps();
    for (int i = 0; i < PERIOD + 50; i++) begin
      @(negedge clk);
      if (period_start === 1'b1) return;
    end
    check("period_start_timeout", 0, 1);
  endtask

  // From a period_start sample, the next PERIOD samples reflect steps 0..255.
  task automatic count_period(output int hr, output int hg, output int hb,
                              output int ps_hits, output logic ps_last);
    hr = 0; hg = 0; hb = 0; ps_hits = 0;
    for (int k = 1; k <= PERIOD; k++) begin
      @(negedge clk);
      hr += int'(pwm_r);
      hg += int'(pwm_g);
      hb += int'(pwm_b);
      ps_hits += int'(period_start);
    end
    ps_last = period_start;
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    n_mis++;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

  // ---------------- directed stimulus ----------------
  initial begin
    int hr, hg, hb, hits;
    logic last;
    int frz_high, frz_ps;
    int rise [3];
    logic [2:0] prev;

    // Reset with in_valid asserted throughout.
    rst = 1'b1; en = 1'b1;
    bus.in_valid = 1'b1; bus.duty_r = 8'd99; bus.duty_g = 8'd99; bus.duty_b = 8'd99;
    repeat (3) @(negedge clk);
    check("reset_outputs", 32'({pwm_r, pwm_g, pwm_b, period_start}), 0);
    check("reset_pending", 32'(bus.pending), 0);
    rst = 1'b0; bus.in_valid = 1'b0;
    wait_ps();
    check("post_reset_pending", 32'(bus.pending), 0);
    count_period(hr, hg, hb, hits, last);
    check("post_reset_r", hr, 0);
    check("post_reset_b", hb, 0);

    // R=64, G=0, B=255.
    strobe(8'd64, 8'd0, 8'd255);
    wait_ps();
    count_period(hr, hg, hb, hits, last);
    check("p1_r", hr, 64);
    count_period(hr, hg, hb, hits, last);
    check("p2_r", hr, 64);
    check("p2_g", hg, 0);
    check("p2_b", hb, 255);
    check("p2_ps_hits", hits, 1);
    check("p2_ps_at_256", 32'(last), 1);

    // Mid-period write R=200 at pwm_cnt=100, old R=50.
    strobe(8'd50, 8'd0, 8'd255);
    wait_ps();
    hr = 0;
    for (int k = 1; k <= PERIOD; k++) begin
      @(negedge clk);
      hr += int'(pwm_r);
      if (k == 101) check("mid_pending_set", 32'(bus.pending), 1);
      if (k == 100) begin
        bus.duty_r = 8'd200; bus.in_valid = 1'b1;
      end else begin
        bus.in_valid = 1'b0;
      end
    end
    check("mid_old_r", hr, 50);
    check("mid_pending_clear", 32'(bus.pending), 0);
    count_period(hr, hg, hb, hits, last);
    check("mid_new_r", hr, 200);

    // Two writes in one period: last wins.
    strobe(8'd10, 8'd0, 8'd255);
    repeat (5) @(negedge clk);
    strobe(8'd20, 8'd0, 8'd255);
    wait_ps();
    count_period(hr, hg, hb, hits, last);
    check("last_write_r", hr, 20);

    // Boundary-cycle write: 40 early in the period, 30 in the boundary cycle.
    strobe(8'd40, 8'd0, 8'd255);
    repeat (254) @(negedge clk);
    strobe(8'd30, 8'd0, 8'd255);
    check("bnd_ps", 32'(period_start), 1);
    check("bnd_pending_kept", 32'(bus.pending), 1);
    count_period(hr, hg, hb, hits, last);
    check("bnd_first_r", hr, 40);
    count_period(hr, hg, hb, hits, last);
    check("bnd_second_r", hr, 30);

    // Freeze for 50 clk at pwm_cnt=30, with a write accepted while frozen.
    strobe(8'd100, 8'd0, 8'd255);
    wait_ps();
    hr = 0; frz_high = 0; frz_ps = 0; hits = 0;
    for (int k = 1; k <= 306; k++) begin
      @(negedge clk);
      if (k <= 30 || k > 80) begin
        hr += int'(pwm_r);
        hits += int'(period_start);
      end else begin
        frz_high += int'(pwm_r | pwm_g | pwm_b);
        frz_ps   += int'(period_start);
      end
      if (k == 41) check("frozen_write_pending", 32'(bus.pending), 1);
      bus.in_valid = (k == 40);
      if (k == 40) bus.duty_r = 8'd120;
      if (k == 30) en = 1'b0;
      if (k == 80) en = 1'b1;
    end
    check("frozen_outputs_high", frz_high, 0);
    check("frozen_ps", frz_ps, 0);
    check("frozen_period_r", hr, 100);
    check("frozen_resume_ps", 32'(period_start), 1);
    check("frozen_resume_ps_hits", hits, 1);
    count_period(hr, hg, hb, hits, last);
    check("after_freeze_r", hr, 120);

`ifdef RGB_PWM_PHASE_STAGGER_EN
    // Staggered phases with R=G=B=16.
    strobe(8'd16, 8'd16, 8'd16);
    wait_ps();
    rise = '{-1, -1, -1};
    hr = 0; hg = 0; hb = 0;
    prev = {pwm_r, pwm_g, pwm_b};
    for (int k = 1; k <= PERIOD; k++) begin
      @(negedge clk);
      if (pwm_r && !prev[2] && rise[0] < 0) rise[0] = k - 1;
      if (pwm_g && !prev[1] && rise[1] < 0) rise[1] = k - 1;
      if (pwm_b && !prev[0] && rise[2] < 0) rise[2] = k - 1;
      hr += int'(pwm_r); hg += int'(pwm_g); hb += int'(pwm_b);
      prev = {pwm_r, pwm_g, pwm_b};
    end
    check("stagger_rise_r", rise[0], 0);
    check("stagger_rise_g", rise[1], 171);
    check("stagger_rise_b", rise[2], 86);
    check("stagger_high_r", hr, 16);
    check("stagger_high_g", hg, 16);
    check("stagger_high_b", hb, 16);
`endif

    // Reset mid-period discards a buffered update and the active duties.
    strobe(8'd77, 8'd77, 8'd77);
    repeat (10) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check("midrst_pending", 32'(bus.pending), 0);
    check("midrst_outputs", 32'({pwm_r, pwm_g, pwm_b, period_start}), 0);
    rst = 1'b0;
    wait_ps();
    count_period(hr, hg, hb, hits, last);
    check("midrst_r", hr, 0);
    check("midrst_g", hg, 0);
    check("midrst_b", hb, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
